// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative multiply/divide unit with architectural HI/LO registers
// Single-cycle multiply, 32-step restoring divide on magnitudes, MTHI/MTLO writes.

module hilo_muldiv (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_value,
   input  logic [31:0] rt_value,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MUL     = 2'd1;
   localparam logic [1:0] S_DIV_RUN = 2'd2;
   localparam logic [1:0] S_DIV_FIX = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic        op_signed;
   logic [31:0] rs_q;
   logic [31:0] rt_q;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] divisor;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;

   logic        accept;
   logic        acc_signed;
   logic [31:0] rs_abs;
   logic [31:0] rt_abs;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic [32:0] rem_shift;
   logic [32:0] diff;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   assign busy = (state != S_IDLE);
   assign done = (state == S_MUL) || (state == S_DIV_FIX);

   assign accept     = start && !busy && !cancel;
   assign acc_signed = (op == OP_MULT) || (op == OP_DIV);
   assign rs_abs     = (acc_signed && rs_value[31]) ? (32'd0 - rs_value) : rs_value;
   assign rt_abs     = (acc_signed && rt_value[31]) ? (32'd0 - rt_value) : rt_value;

   // Sign-extending to 64 bits makes the truncated unsigned product correct for MULT too.
   assign mul_a   = {{32{op_signed & rs_q[31]}}, rs_q};
   assign mul_b   = {{32{op_signed & rt_q[31]}}, rt_q};
   assign product = mul_a * mul_b;

   assign rem_shift = {rem, quo[31]};
   assign diff      = rem_shift - {1'b0, divisor};

   assign q_fix = neg_q ? (32'd0 - quo) : quo;
   assign r_fix = neg_r ? (32'd0 - rem) : rem;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         cnt       <= 5'd0;
         op_signed <= 1'b0;
         rs_q      <= 32'd0;
         rt_q      <= 32'd0;
         quo       <= 32'd0;
         rem       <= 32'd0;
         divisor   <= 32'd0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_zero  <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_signed <= acc_signed;
                  rs_q      <= rs_value;
                  rt_q      <= rt_value;
                  case (op)
                     OP_MTHI: hi <= rs_value;
                     OP_MTLO: lo <= rs_value;
                     OP_MULT, OP_MULTU: state <= S_MUL;
                     OP_DIV, OP_DIVU: begin
                        state    <= S_DIV_RUN;
                        cnt      <= 5'd0;
                        quo      <= rs_abs;
                        rem      <= 32'd0;
                        divisor  <= rt_abs;
                        neg_q    <= acc_signed && (rs_value[31] ^ rt_value[31]);
                        neg_r    <= acc_signed && rs_value[31];
                        div_zero <= (rt_value == 32'd0);
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               if (!cancel) {hi, lo} <= product;
               state <= S_IDLE;
            end
            S_DIV_RUN: begin
               if (cancel) begin
                  state <= S_IDLE;
               end else begin
                  // Restoring step: keep the trial remainder only when it did not borrow.
                  if (!diff[32]) begin
                     rem <= diff[31:0];
                     quo <= {quo[30:0], 1'b1};
                  end else begin
                     rem <= rem_shift[31:0];
                     quo <= {quo[30:0], 1'b0};
                  end
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) state <= S_DIV_FIX;
               end
            end
            S_DIV_FIX: begin
               if (!cancel) begin
                  if (div_zero) begin
                     lo <= 32'hFFFF_FFFF;
                     hi <= rs_q;
                  end else begin
                     lo <= q_fix;
                     hi <= r_fix;
                  end
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_hilo_muldiv;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_value;
   logic [31:0] rt_value;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   hilo_muldiv dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .op       (op),
      .rs_value (rs_value),
      .rt_value (rt_value),
      .cancel   (cancel),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle start pulse; returns just after the accepting edge E0.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      op       = o;
      rs_value = a;
      rt_value = b;
      step();
      start    = 1'b0;
      rs_value = 32'h0;
      rt_value = 32'h0;
   endtask

   task automatic run_mul(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
      issue(o, a, b);
      chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done1"}, {31'd0, done}, 32'd1);
      step();
      chk({tag, "_busy2"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
      int n_busy;
      int n_done;
      int done_at;
      n_busy  = 0;
      n_done  = 0;
      done_at = 0;
      issue(o, a, b);
      while (busy && n_busy < 40) begin
         n_busy++;
         if (done) begin
            n_done++;
            done_at = n_busy;
         end
         step();
      end
      chk({tag, "_busy_cycles"}, n_busy, 32'd33);
      chk({tag, "_done_count"}, n_done, 32'd1);
      chk({tag, "_done_at"}, done_at, 32'd33);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int n;
      resetn   = 1'b0;
      start    = 1'b0;
      op       = 3'd0;
      rs_value = 32'h0;
      rt_value = 32'h0;
      cancel   = 1'b0;
      step();
      step();
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      step();

      run_mul("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_mul("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);

      run_div("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_div("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
      run_div("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_div("divu_zero", 3'd3, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);

      // Cancel in busy cycle 10 of DIV 100/7; prior HI/LO come from the divide-by-zero.
      issue(3'd2, 32'd100, 32'd7);
      for (int i = 1; i < 10; i++) step();
      chk("cancel_busy_before", {31'd0, busy}, 32'd1);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("cancel_busy_after", {31'd0, busy}, 32'd0);
      chk("cancel_hi", hi, 32'h1234_5678);
      chk("cancel_lo", lo, 32'hFFFF_FFFF);
      issue(3'd5, 32'hA5A5_A5A5, 32'h0);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      chk("mtlo_lo", lo, 32'hA5A5_A5A5);
      chk("mtlo_hi", hi, 32'h1234_5678);

      // MULT offered while DIVU 100/7 is busy must be ignored.
      issue(3'd3, 32'd100, 32'd7);
      step();
      step();
      issue(3'd0, 32'd5, 32'd5);
      n = 0;
      while (busy && n < 40) begin
         n++;
         step();
      end
      chk("ign_busy_bound", {31'd0, busy}, 32'd0);
      chk("ign_hi", hi, 32'd2);
      chk("ign_lo", lo, 32'd14);
      step();
      chk("ign_no_mul", {31'd0, busy}, 32'd0);
      chk("ign_lo_hold", lo, 32'd14);

      // MTHI together with cancel is dropped.
      cancel = 1'b1;
      issue(3'd4, 32'hDEAD_BEEF, 32'h0);
      cancel = 1'b0;
      step();
      chk("mthi_cancel_hi", hi, 32'd2);
      chk("mthi_cancel_lo", lo, 32'd14);

      // Asynchronous reset in busy cycle 20 of a DIV.
      issue(3'd2, 32'hFFFF_FF9C, 32'd7);
      for (int i = 1; i < 20; i++) step();
      chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_hi", hi, 32'h0);
      chk("rst_mid_lo", lo, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      step();
      run_div("div_after_rst", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14);
      run_div("div_neg_dividend", 3'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the execute stage, operating alongside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage using the same `rs_value`/`rt_value` operands the ALU consumes. It holds `busy` while an operation is in flight so the pipeline can stall. The HI/LO values it drives feed MFHI/MFLO through the execute-stage result mux.

## Interface
- No parameters.
- `clk`  in  1  clock; all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid; sampled only when `busy`=0.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved (accepted as no-op).
- `rs_value`  in  32  dividend / multiplicand / MTHI-MTLO source.
- `rt_value`  in  32  divisor / multiplier.
- `cancel`  in  1  pipeline flush; aborts the in-flight op and blocks a same-cycle start.
- `busy`  out  1  high while a MUL/DIV is in flight.
- `done`  out  1  high in the final cycle of a MUL/DIV; HI/LO update at the end of that cycle.
- `hi`  out  32  HI register value.
- `lo`  out  32  LO register value.

## Operation
- **States:** IDLE, MUL, DIV_RUN, DIV_FIX. `busy` = (state != IDLE). `done` = (state == MUL) | (state == DIV_FIX), combinational from state.
- **Accept:** an edge with `start & ~busy & ~cancel` latches `op`, `rs_value` and `rt_value`.
  - MTHI: `hi` <= `rs_value` at that edge; state stays IDLE.
  - MTLO: `lo` <= `rs_value` at that edge; state stays IDLE.
  - MULT/MULTU: go to MUL.
  - DIV/DIVU: go to DIV_RUN with the iteration counter at 0.
- **MUL:**
  - Full 32x32 -> 64 product, signed for MULT, unsigned for MULTU.
  - At the next edge `{hi,lo}` <= product and state goes to IDLE.
- **DIV_RUN:**
  - Radix-2 restoring division on magnitudes.
  - For DIV, operands are the absolute values of `rs_value` and `rt_value`, treated as 32-bit unsigned.
  - One quotient bit per edge; 32 edges; the counter runs 0..31, then the state goes to DIV_FIX.
- **DIV_FIX (one cycle):**
  - For DIV, negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - At the edge, `lo` <= quotient and `hi` <= remainder; state goes to IDLE.
- **Divide by zero** (`rt_value`==0 at accept):
  - Same 33-cycle timing.
  - Result is forced to `lo`=32'hFFFFFFFF and `hi`=latched `rs_value`, for both DIV and DIVU.
- **Overflow case** (DIV 0x80000000 / 0xFFFFFFFF): `lo`=32'h80000000, `hi`=0. This falls out of the magnitude path; no exception is raised.
- **Cancel:**
  - When `cancel`=1, the next edge forces state to IDLE with HI/LO unchanged.
  - If the state is MUL or DIV_FIX in that cycle, the write is suppressed.
  - `cancel` with `start` in IDLE: the start is ignored, including MTHI/MTLO.
- **Start while busy:** ignored. The upstream stage must hold the instruction stalled on `busy`.
- **Reset mid-operation:** immediate return to IDLE; `hi`=`lo`=0.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- MTHI/MTLO: new value visible on `hi`/`lo` in the cycle after the accepting edge E0. `busy` stays low.
- MULT/MULTU:
  - `busy`=`done`=1 for exactly 1 cycle (after E0).
  - Result visible the cycle after E1.
  - A new start can be accepted at E2.
- DIV/DIVU:
  - `busy`=1 for 33 cycles (after E0 through after E32).
  - `done`=1 only in the 33rd cycle.
  - HI/LO are written at E33 and are visible after it.
  - A new start can be accepted at E33 only if `busy` is low in that cycle, which it is not; the earliest acceptance is E34.
- `hi`/`lo` hold their old values throughout an in-flight op. Consumers must stall MFHI/MFLO on `busy`.

## Test plan
- Reset, then MULT `rs`=0xFFFFFFFE, `rt`=3 -> `busy` high 1 cycle; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV `rs`=0xFFFFFFF9 (-7), `rt`=2 -> `busy` 33 cycles, `done` only in the last; `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with the same operands -> `lo`=0x7FFFFFFC, `hi`=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. DIVU 0x12345678 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678 after 33 cycles.
- DIV 100/7 with `cancel` pulsed in busy cycle 10 -> `busy` low next cycle; HI/LO keep prior values. A new MTLO 0xA5A5A5A5 is accepted the following cycle; `lo` updates and `hi` is unchanged.
- Start MULT while a DIV is busy -> ignored; the DIV result is correct. MTHI with `cancel`=1 -> `hi` unchanged.
- Assert `resetn`=0 mid-DIV (cycle 20) -> `busy`, `done`, `hi` and `lo` all 0 immediately and asynchronously; a DIV after reset release completes correctly.
